axi_rdata_checker: RTL and testbench

AXI_RDATA_CHECKER -- requirements
Module: axi_rdata_checker

---
 rtl/memtest_pkg.sv | 25 ++
 rtl/lane_first_set.sv | 19 +
 rtl/axi_rdata_checker.sv | 203 ++++++++++++++++++++
 tb/tb_axi_rdata_checker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/memtest_pkg.sv
// Shared definitions for the AXI read-data pattern checker.
// - state_e        : checker FSM states
// - RESP_OKAY      : AXI RRESP value for a good beat
// - RESP_ERR_LANE  : lane index reported when only RRESP was bad
// - lane_count()   : pattern lanes per read-data beat (L)
package memtest_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [5:0] RESP_ERR_LANE = 6'd63;

  function automatic int unsigned lane_count(input int unsigned bus_w,
                                             input int unsigned data_w);
    return bus_w / data_w;
  endfunction

  localparam int unsigned LANE_CNT = lane_count(512, 16);

endpackage

// File: rtl/lane_first_set.sv
// Priority encoder: index of the lowest set bit of i_vec (0 when none set).
// - i_vec : mismatch vector, one bit per lane
// - o_idx : lowest set bit index
module lane_first_set #(
  parameter int unsigned pWidth = 32
) (
  input  logic [pWidth-1:0] i_vec,
  output logic [5:0]        o_idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int unsigned i = pWidth; i > 0; i--) begin
      if (i_vec[i-1]) o_idx = 6'(i - 1);
    end
  end

endmodule

// File: rtl/axi_rdata_checker.sv
// Passive AXI4 read-data checker. Each accepted beat n is compared lane by
// lane against (x + n*L) mod 2^pDataBitWidth; errors and RLAST placement
// violations are reported through sticky, registered result outputs.
// - iCLK, iRST          : clock, asynchronous active-low reset
// - i_start             : pulse; clears results and (re)arms a pass
// - i_rdata..i_rresp    : monitored read-data channel
// - o_busy / o_done     : pass in progress / pass complete
// - o_fail, o_err_cnt   : error seen, saturating erroneous-beat count
// - o_fail_beat/lane    : location of the first erroneous beat
// - o_proto_err         : RLAST position violation seen
module axi_rdata_checker
  import memtest_pkg::*;
#(
  parameter int pAxi4BusWidth = 512,
  parameter int pDataBitWidth = 16,
  parameter int pBurstLen     = 16,
  parameter int pBeatTotal    = 65536
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     i_start,
  input  logic [pAxi4BusWidth-1:0] i_rdata,
  input  logic                     i_rvalid,
  input  logic                     i_rready,
  input  logic                     i_rlast,
  input  logic [1:0]               i_rresp,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_fail,
  output logic [15:0]              o_err_cnt,
  output logic [31:0]              o_fail_beat,
  output logic [5:0]               o_fail_lane,
  output logic                     o_proto_err
);

  localparam int unsigned L = lane_count(pAxi4BusWidth, pDataBitWidth);
  localparam int unsigned W = pDataBitWidth;
  localparam logic [W-1:0] LANE_STEP = W'(L);

  state_e         state_q, state_d;
  logic           drain_q, drain_d;
  logic [W-1:0]   exp_q [L];
  logic [W-1:0]   exp_d [L];
  logic [31:0]    beat_q, beat_d;
  logic [31:0]    burst_q, burst_d;

  logic           s1_valid_q, s1_valid_d;
  logic [L-1:0]   s1_mis_q, s1_mis_d;
  logic           s1_resp_q, s1_resp_d;
  logic           s1_proto_q, s1_proto_d;
  logic [31:0]    s1_beat_q, s1_beat_d;

  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           fail_q, fail_d;
  logic           proto_q, proto_d;
  logic [15:0]    err_cnt_q, err_cnt_d;
  logic [31:0]    fail_beat_q, fail_beat_d;
  logic [5:0]     fail_lane_q, fail_lane_d;

  logic [L-1:0]   mis;
  logic [5:0]     first_lane;
  logic           accept;
  logic           rlast_bad;

  lane_first_set #(.pWidth(L)) u_first (
    .i_vec (s1_mis_q),
    .o_idx (first_lane)
  );

  always_comb begin
    for (int unsigned i = 0; i < L; i++) begin
      mis[i] = (i_rdata[i*W +: W] != exp_q[i]);
    end
    accept    = (state_q == ST_RUN) && i_rvalid && i_rready;
    rlast_bad = (burst_q == 32'(pBurstLen - 1)) ? !i_rlast : i_rlast;

    state_d     = state_q;
    drain_d     = drain_q;
    exp_d       = exp_q;
    beat_d      = beat_q;
    burst_d     = burst_q;
    s1_valid_d  = 1'b0;
    s1_mis_d    = s1_mis_q;
    s1_resp_d   = s1_resp_q;
    s1_proto_d  = s1_proto_q;
    s1_beat_d   = s1_beat_q;
    fail_d      = fail_q;
    proto_d     = proto_q;
    err_cnt_d   = err_cnt_q;
    fail_beat_d = fail_beat_q;
    fail_lane_d = fail_lane_q;

    // Stage 2: fold the registered beat result into the sticky results.
    if (s1_valid_q) begin
      if (s1_proto_q) proto_d = 1'b1;
      if ((|s1_mis_q) || s1_resp_q) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        if (!fail_q) begin
          fail_d      = 1'b1;
          fail_beat_d = s1_beat_q;
          fail_lane_d = (|s1_mis_q) ? first_lane : RESP_ERR_LANE;
        end
      end
    end

    // Stage 1 and sequencing.
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          s1_valid_d = 1'b1;
          s1_mis_d   = mis;
          s1_resp_d  = (i_rresp != RESP_OKAY);
          s1_proto_d = rlast_bad;
          s1_beat_d  = beat_q;
          for (int unsigned i = 0; i < L; i++) exp_d[i] = exp_q[i] + LANE_STEP;
          beat_d  = beat_q + 32'd1;
          burst_d = (burst_q == 32'(pBurstLen - 1)) ? '0 : burst_q + 32'd1;
          if (beat_q == 32'(pBeatTotal - 1)) begin
            state_d = ST_DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q) state_d = ST_DONE;
        else         drain_d = 1'b1;
      end
      default: ;
    endcase

    // Start wins over everything, including a beat presented in the same cycle.
    if (i_start) begin
      state_d     = ST_RUN;
      drain_d     = 1'b0;
      for (int unsigned i = 0; i < L; i++) exp_d[i] = W'(i);
      beat_d      = '0;
      burst_d     = '0;
      s1_valid_d  = 1'b0;
      s1_mis_d    = '0;
      s1_resp_d   = 1'b0;
      s1_proto_d  = 1'b0;
      s1_beat_d   = '0;
      fail_d      = 1'b0;
      proto_d     = 1'b0;
      err_cnt_d   = '0;
      fail_beat_d = '0;
      fail_lane_d = '0;
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q     <= ST_IDLE;
      drain_q     <= 1'b0;
      for (int unsigned i = 0; i < L; i++) exp_q[i] <= W'(i);
      beat_q      <= '0;
      burst_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_mis_q    <= '0;
      s1_resp_q   <= 1'b0;
      s1_proto_q  <= 1'b0;
      s1_beat_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      proto_q     <= 1'b0;
      err_cnt_q   <= '0;
      fail_beat_q <= '0;
      fail_lane_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      exp_q       <= exp_d;
      beat_q      <= beat_d;
      burst_q     <= burst_d;
      s1_valid_q  <= s1_valid_d;
      s1_mis_q    <= s1_mis_d;
      s1_resp_q   <= s1_resp_d;
      s1_proto_q  <= s1_proto_d;
      s1_beat_q   <= s1_beat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      proto_q     <= proto_d;
      err_cnt_q   <= err_cnt_d;
      fail_beat_q <= fail_beat_d;
      fail_lane_q <= fail_lane_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_fail      = fail_q;
  assign o_proto_err = proto_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_fail_beat = fail_beat_q;
  assign o_fail_lane = fail_lane_q;

endmodule

// File: tb/tb_axi_rdata_checker.sv
// Directed bench for axi_rdata_checker (512-bit bus, 16-bit lanes, 16-beat
// bursts, 64 beats per pass).
module tb_axi_rdata_checker;

  localparam int BUS = 512;
  localparam int DW  = 16;
  localparam int BL  = 16;
  localparam int TOT = 64;

  logic           iCLK = 1'b0;
  logic           iRST = 1'b0;
  logic           i_start = 1'b0;
  logic [BUS-1:0] i_rdata = '0;
  logic           i_rvalid = 1'b0;
  logic           i_rready = 1'b0;
  logic           i_rlast = 1'b0;
  logic [1:0]     i_rresp = 2'b00;
  logic           o_busy, o_done, o_fail, o_proto_err;
  logic [15:0]    o_err_cnt;
  logic [31:0]    o_fail_beat;
  logic [5:0]     o_fail_lane;

  int errors = 0;
  int checks = 0;

  axi_rdata_checker #(
    .pAxi4BusWidth (BUS),
    .pDataBitWidth (DW),
    .pBurstLen     (BL),
    .pBeatTotal    (TOT)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .i_start     (i_start),
    .i_rdata     (i_rdata),
    .i_rvalid    (i_rvalid),
    .i_rready    (i_rready),
    .i_rlast     (i_rlast),
    .i_rresp     (i_rresp),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_fail      (o_fail),
    .o_err_cnt   (o_err_cnt),
    .o_fail_beat (o_fail_beat),
    .o_fail_lane (o_fail_lane),
    .o_proto_err (o_proto_err)
  );

  always #5 iCLK = ~iCLK;

  // Lane x of beat n carries x + 32*n (mod 2^16).
  function automatic logic [BUS-1:0] pat(input int n);
    logic [BUS-1:0] v;
    for (int x = 0; x < BUS/DW; x++) v[x*DW +: DW] = 16'(x + n*(BUS/DW));
    return v;
  endfunction

  function automatic logic last_of(input int n);
    return (n % BL) == (BL - 1);
  endfunction

  task automatic tick();
    @(posedge iCLK); #1;
  endtask

  task automatic send(input logic [BUS-1:0] d, input logic [1:0] resp, input logic last);
    i_rvalid = 1'b1; i_rready = 1'b1; i_rdata = d; i_rresp = resp; i_rlast = last;
    tick();
    i_rvalid = 1'b0; i_rready = 1'b0; i_rlast = 1'b0; i_rresp = 2'b00;
  endtask

  task automatic pulse_start();
    i_start = 1'b1; tick(); i_start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 10; i++) begin
      if (o_done) break;
      tick();
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0b exp=0", o_done); end
    checks++; if (o_fail !== 1'b0) begin errors++; $display("FAIL rst_fail got=%0b exp=0", o_fail); end
    checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto got=%0b exp=0", o_proto_err); end
    checks++; if (o_err_cnt !== 16'd0) begin errors++; $display("FAIL rst_errcnt got=%0h exp=0", o_err_cnt); end
    checks++; if (o_fail_beat !== 32'd0) begin errors++; $display("FAIL rst_beat got=%0h exp=0", o_fail_beat); end
    checks++; if (o_fail_lane !== 6'd0) begin errors++; $display("FAIL rst_lane got=%0h exp=0", o_fail_lane); end
    @(negedge iCLK); iRST = 1'b1; tick();
    // Beats in IDLE are ignored.
    for (int n = 0; n < 4; n++) send('0, 2'b10, 1'b1);
    tick(); tick();
    checks++; if (o_fail !== 1'b0) begin errors++; $display("FAIL idle_fail got=%0b exp=0", o_fail); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%0b exp=0", o_busy); end
  endtask

  task automatic test_clean_pass();
    pulse_start();
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL clean_busy got=%0b exp=1", o_busy); end
    for (int n = 0; n < TOT; n++) send(pat(n), 2'b00, last_of(n));
    checks++; if (o_done !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL clean_drain got=%0b%0b exp=01", o_done, o_busy); end
    wait_done();
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL clean_done got=%0b exp=1", o_done); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL clean_busy_end got=%0b exp=0", o_busy); end
    checks++; if (o_fail !== 1'b0) begin errors++; $display("FAIL clean_fail got=%0b exp=0", o_fail); end
    checks++; if (o_err_cnt !== 16'd0) begin errors++; $display("FAIL clean_errcnt got=%0h exp=0", o_err_cnt); end
    checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL clean_proto got=%0b exp=0", o_proto_err); end
    // Beats in DONE are ignored.
    send('0, 2'b10, 1'b1); tick(); tick();
    checks++; if (o_fail !== 1'b0 || o_done !== 1'b1) begin errors++; $display("FAIL done_ignore got=%0b%0b exp=01", o_fail, o_done); end
  endtask

  task automatic test_data_error();
    logic [BUS-1:0] d;
    pulse_start();
    for (int n = 0; n < TOT; n++) begin
      d = pat(n);
      if (n == 5) d[3*DW +: DW] = 16'h0000;
      send(d, 2'b00, last_of(n));
      if (n == 5) begin
        checks++; if (o_fail !== 1'b0) begin errors++; $display("FAIL derr_early got=%0b exp=0", o_fail); end
      end
      if (n == 6) begin
        checks++; if (o_fail !== 1'b1) begin errors++; $display("FAIL derr_timing got=%0b exp=1", o_fail); end
      end
    end
    wait_done();
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL derr_done got=%0b exp=1", o_done); end
    checks++; if (o_fail_beat !== 32'd5) begin errors++; $display("FAIL derr_beat got=%0d exp=5", o_fail_beat); end
    checks++; if (o_fail_lane !== 6'd3) begin errors++; $display("FAIL derr_lane got=%0d exp=3", o_fail_lane); end
    checks++; if (o_err_cnt !== 16'd1) begin errors++; $display("FAIL derr_errcnt got=%0d exp=1", o_err_cnt); end
  endtask

  task automatic test_resp_error();
    pulse_start();
    for (int n = 0; n < TOT; n++) send(pat(n), (n == 0) ? 2'b10 : 2'b00, last_of(n));
    wait_done();
    checks++; if (o_fail !== 1'b1) begin errors++; $display("FAIL rerr_fail got=%0b exp=1", o_fail); end
    checks++; if (o_fail_lane !== 6'd63) begin errors++; $display("FAIL rerr_lane got=%0d exp=63", o_fail_lane); end
    checks++; if (o_fail_beat !== 32'd0) begin errors++; $display("FAIL rerr_beat got=%0d exp=0", o_fail_beat); end
    checks++; if (o_err_cnt !== 16'd1) begin errors++; $display("FAIL rerr_errcnt got=%0d exp=1", o_err_cnt); end
  endtask

  task automatic test_backpressure();
    pulse_start();
    for (int n = 0; n < TOT; n++) begin
      // Garbage while not ready must never be sampled.
      i_rvalid = 1'b1; i_rready = 1'b0; i_rdata = '0; i_rresp = 2'b11; i_rlast = 1'b1;
      tick();
      i_rready = 1'b1; i_rdata = pat(n); i_rresp = 2'b00; i_rlast = last_of(n);
      tick();
      if (n == 31) begin
        checks++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin errors++; $display("FAIL bp_mid got=%0b%0b exp=10", o_busy, o_done); end
      end
    end
    i_rvalid = 1'b0; i_rready = 1'b0; i_rlast = 1'b0;
    wait_done();
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL bp_done got=%0b exp=1", o_done); end
    checks++; if (o_fail !== 1'b0) begin errors++; $display("FAIL bp_fail got=%0b exp=0", o_fail); end
    checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL bp_proto got=%0b exp=0", o_proto_err); end
  endtask

  task automatic test_rlast();
    pulse_start();
    for (int n = 0; n < TOT; n++) send(pat(n), 2'b00, last_of(n) || (n == 14));
    wait_done();
    checks++; if (o_proto_err !== 1'b1) begin errors++; $display("FAIL rlast_proto got=%0b exp=1", o_proto_err); end
    checks++; if (o_fail !== 1'b0) begin errors++; $display("FAIL rlast_fail got=%0b exp=0", o_fail); end
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL rlast_done got=%0b exp=1", o_done); end
  endtask

  task automatic test_restart();
    logic [BUS-1:0] d;
    pulse_start();
    for (int n = 0; n < 30; n++) begin
      d = pat(n);
      if (n == 2) d[0 +: DW] = 16'hBEEF;
      send(d, 2'b00, last_of(n));
    end
    checks++; if (o_fail !== 1'b1 || o_err_cnt !== 16'd1) begin errors++; $display("FAIL rs_pre got=%0b/%0d exp=1/1", o_fail, o_err_cnt); end
    // Bad beat presented in the start cycle must be ignored.
    d = pat(30); d[0 +: DW] = 16'hDEAD;
    i_start = 1'b1; i_rvalid = 1'b1; i_rready = 1'b1; i_rdata = d;
    tick();
    i_start = 1'b0; i_rvalid = 1'b0; i_rready = 1'b0;
    checks++; if (o_fail !== 1'b0 || o_err_cnt !== 16'd0) begin errors++; $display("FAIL rs_clear got=%0b/%0d exp=0/0", o_fail, o_err_cnt); end
    checks++; if (o_fail_beat !== 32'd0 || o_fail_lane !== 6'd0) begin errors++; $display("FAIL rs_loc got=%0d/%0d exp=0/0", o_fail_beat, o_fail_lane); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rs_busy got=%0b exp=1", o_busy); end
    send(pat(0), 2'b00, 1'b0);
    tick(); tick();
    checks++; if (o_fail !== 1'b0) begin errors++; $display("FAIL rs_first got=%0b exp=0", o_fail); end
    for (int n = 1; n < TOT; n++) begin
      send(pat(n), 2'b00, last_of(n));
      if (n == 62) begin
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rs_early_done got=%0b exp=0", o_done); end
      end
    end
    wait_done();
    checks++; if (o_done !== 1'b1 || o_fail !== 1'b0) begin errors++; $display("FAIL rs_end got=%0b%0b exp=10", o_done, o_fail); end
  endtask

  task automatic test_reset_abort();
    pulse_start();
    for (int n = 0; n < 3; n++) send(pat(n), 2'b00, last_of(n));
    iRST = 1'b0; #2;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0b exp=0", o_busy); end
    @(negedge iCLK); iRST = 1'b1; tick();
    for (int n = 0; n < 3; n++) send('0, 2'b10, 1'b1);
    tick(); tick();
    checks++; if (o_busy !== 1'b0 || o_fail !== 1'b0) begin errors++; $display("FAIL abort_idle got=%0b%0b exp=00", o_busy, o_fail); end
  endtask

  initial begin
    test_reset();
    test_clean_pass();
    test_data_error();
    test_resp_error();
    test_backpressure();
    test_rlast();
    test_restart();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
